bht_update_queue: RTL

- FIFO between the branch-resolution stage (MEM) and the local 2-bit branch history table's write port.
- Accepts one resolved branch per cycle: PC, actual outcome, predicted outcome.
- Retires one entry per cycle into the BHT training interface (write, write_pc, taken).
- Decouples resolution timing from table updates; the BHT can be held off while a fetch-side read conflicts.

---
 rtl/bht_update_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/bht_update_queue.sv
// Resolved-branch FIFO feeding the local 2-bit BHT write port (strict order, no bypass).
// Optional hit/mispredict statistics are enabled by defining BHT_UPD_STATS_EN.
module bht_update_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [15:0]      res_pc,
  input  logic             res_taken,
  input  logic             res_predicted,
  input  logic             bht_hold,
  output logic             bht_write,
  output logic [15:0]      bht_write_pc,
  output logic             bht_taken,
  output logic [PTR_W:0]   count,
  output logic             empty
`ifdef BHT_UPD_STATS_EN
  ,
  output logic [15:0]      stat_branches,
  output logic [15:0]      stat_mispredicts
`endif
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [15:0]      pc_mem    [DEPTH];
  logic             taken_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W:0]   count_next;
  logic             empty_int;
  logic             push;
  logic             pop;

  // Outputs are forced to the idle state while reset is asserted, so the
  // reset cycle itself already looks empty and ready.
  assign empty_int    = !reset_n || (count_reg == '0);
  assign empty        = empty_int;
  assign count        = reset_n ? count_reg : '0;
  assign bht_write    = !empty_int && !bht_hold;
  assign res_ready    = !reset_n || (count_reg != FULL_COUNT) || bht_write;
  assign bht_write_pc = empty_int ? 16'h0000 : pc_mem[rd_ptr_reg];
  assign bht_taken    = empty_int ? 1'b0 : taken_mem[rd_ptr_reg];

  assign push = reset_n && res_valid && res_ready;
  assign pop  = bht_write;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset: contents are only observed once counted valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        pc_mem[gi]    <= res_pc;
        taken_mem[gi] <= res_taken;
      end
    end
  end

`ifdef BHT_UPD_STATS_EN
  logic pred_mem [DEPTH];
  logic mispredict;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pred
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PTR_W'(gi))) pred_mem[gi] <= res_predicted;
    end
  end

  assign mispredict = taken_mem[rd_ptr_reg] != pred_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (pop) begin
      if (stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if (mispredict && (stat_mispredicts != 16'hFFFF))
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`else
  logic predicted_unused;
  assign predicted_unused = res_predicted;
`endif

endmodule
